// File: rtl/page_ram_write_arbiter.sv
// rtl/page_ram_write_arbiter.sv - page RAM write-port arbiter with burst lock and read sequencing
//
// Purpose:
//   Shares the single write port of the packet-scheduler page RAM between
//   N_REQ ingress writers. Arbitration is round-robin. A multi-beat burst locks
//   the port to its owner until the owner's last beat is accepted. The module
//   also drives the RAM read port for one reader, with a fixed 1-cycle response.
//
// Optional feature macro: PAGE_ARB_LOCK_TIMEOUT_EN
//   When it is defined, a lock whose owner stays idle for TIMEOUT_CYCLES
//   cycles is released and lock_abort pulses for one cycle. When it is not
//   defined, the lock is held until the owner's last beat and lock_abort is 0.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/last      per-requester beat valid / last beat of burst
//   req_addr/data       packed per-requester address / data, requester i at slice i
//   req_ready           per-requester accept (combinational)
//   rd_req, rd_addr     read request (always accepted) and read address
//   rd_rsp_valid/data   read response, 1 cycle after rd_req
//   ram_we/write_addr/data  registered write port to the RAM
//   ram_read_addr, ram_q    RAM read port (ram_q valid 1 cycle after the address)
//   busy                burst lock held
//   lock_abort          one-cycle pulse when a lock is forcibly released
module page_ram_write_arbiter #(
  parameter int N_REQ          = 4,
  parameter int DATA_WIDTH     = 40,
  parameter int ADDR_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        rd_req,
  input  logic [ADDR_WIDTH-1:0]       rd_addr,
  output logic                        rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]       rd_rsp_data,
  output logic                        ram_we,
  output logic [ADDR_WIDTH-1:0]       ram_write_addr,
  output logic [DATA_WIDTH-1:0]       ram_data,
  output logic [ADDR_WIDTH-1:0]       ram_read_addr,
  input  logic [DATA_WIDTH-1:0]       ram_q,
  output logic                        busy,
  output logic                        lock_abort
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int SUM_W = PTR_W + 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [PTR_W-1:0] rr_ptr, rr_ptr_nxt;
  logic [PTR_W-1:0] owner, owner_nxt;

  logic [PTR_W-1:0] win_idx, acc_idx, cand;
  logic [SUM_W-1:0] sum;
  logic             win_found, accept, sel_last, abort;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_data;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(N_REQ - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    win_found  = 1'b0;
    win_idx    = '0;
    cand       = '0;
    sum        = '0;
    req_ready  = '0;
    acc_idx    = '0;
    sel_last   = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    owner_nxt  = owner;

    // Scan offsets from the far end toward rr_ptr so that the valid
    // requester closest to rr_ptr (modulo N_REQ) is the last to be written.
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (sum >= SUM_W'(N_REQ)) sum = sum - SUM_W'(N_REQ);
      cand = sum[PTR_W-1:0];
      if (req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end

    if (state == IDLE) begin
      acc_idx = win_idx;
      if (win_found) req_ready[win_idx] = 1'b1;
    end else begin
      acc_idx = owner;
      req_ready[owner] = 1'b1;
    end

    accept = |(req_valid & req_ready);

    for (int i = 0; i < N_REQ; i++) begin
      if (PTR_W'(i) == acc_idx) begin
        sel_last = req_last[i];
        sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    case (state)
      IDLE: begin
        if (accept) begin
          if (sel_last) begin
            rr_ptr_nxt = next_ptr(acc_idx);
          end else begin
            state_nxt = LOCKED;
            owner_nxt = acc_idx;
          end
        end
      end
      LOCKED: begin
        // A timed-out lock is dropped even if the owner wakes up in the
        // abort cycle; that beat is still written.
        if ((accept && sel_last) || abort) begin
          state_nxt  = IDLE;
          rr_ptr_nxt = next_ptr(owner);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      rr_ptr         <= '0;
      owner          <= '0;
      ram_we         <= 1'b0;
      ram_write_addr <= '0;
      ram_data       <= '0;
      rd_rsp_valid   <= 1'b0;
    end else begin
      state        <= state_nxt;
      rr_ptr       <= rr_ptr_nxt;
      owner        <= owner_nxt;
      ram_we       <= accept;
      rd_rsp_valid <= rd_req;
      if (accept) begin
        ram_write_addr <= sel_addr;
        ram_data       <= sel_data;
      end
    end
  end

`ifdef PAGE_ARB_LOCK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             lock_abort_q;

  assign abort = (state == LOCKED) && (to_cnt == CNT_W'(TIMEOUT_CYCLES));

  // The counter is held at 0 outside LOCKED, which also clears it on lock entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt       <= '0;
      lock_abort_q <= 1'b0;
    end else begin
      lock_abort_q <= abort;
      if (state != LOCKED || state_nxt != LOCKED || accept) to_cnt <= '0;
      else                                                  to_cnt <= to_cnt + 1'b1;
    end
  end

  assign lock_abort = lock_abort_q;
`else
  assign abort      = 1'b0;
  assign lock_abort = 1'b0;
`endif

  assign busy          = (state == LOCKED);
  assign ram_read_addr = rd_addr;
  assign rd_rsp_data   = ram_q;

endmodule

// File: tb/tb_page_ram_write_arbiter.sv
// tb/tb_page_ram_write_arbiter.sv - directed self-checking bench for page_ram_write_arbiter
module tb_page_ram_write_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_last;
  logic [63:0]  req_addr;
  logic [159:0] req_data;
  logic [3:0]   req_ready;
  logic         rd_req;
  logic [15:0]  rd_addr;
  logic         rd_rsp_valid;
  logic [39:0]  rd_rsp_data;
  logic         ram_we;
  logic [15:0]  ram_write_addr;
  logic [39:0]  ram_data;
  logic [15:0]  ram_read_addr;
  logic [39:0]  ram_q;
  logic         busy;
  logic         lock_abort;

  int n_cmp = 0;
  int n_err = 0;

  page_ram_write_arbiter #(
    .N_REQ(4), .DATA_WIDTH(40), .ADDR_WIDTH(16), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_last(req_last), .req_addr(req_addr), .req_data(req_data),
    .req_ready(req_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rsp_valid(rd_rsp_valid), .rd_rsp_data(rd_rsp_data),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr), .ram_data(ram_data),
    .ram_read_addr(ram_read_addr), .ram_q(ram_q),
    .busy(busy), .lock_abort(lock_abort)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Page RAM model: writes land on the edge where ram_we is high; a read of
  // the same address on that edge sees the new data.
  logic [39:0] mem [logic [15:0]];
  always @(posedge clk) begin
    if (ram_we && ram_write_addr == ram_read_addr) ram_q <= ram_data;
    else if (mem.exists(ram_read_addr))            ram_q <= mem[ram_read_addr];
    else                                           ram_q <= 40'h0;
    if (ram_we) mem[ram_write_addr] = ram_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_req(input int i, input logic v, input logic l,
                         input logic [15:0] a, input logic [39:0] d);
    req_valid[i] = v;
    req_last[i]  = l;
    req_addr[i*16 +: 16] = a;
    req_data[i*40 +: 40] = d;
  endtask

  task automatic clear_inputs();
    req_valid = '0;
    req_last  = '0;
    req_addr  = '0;
    req_data  = '0;
    rd_req    = 1'b0;
    rd_addr   = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({ram_we, busy, rd_rsp_valid, lock_abort} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_flags: got we/busy/rsp/abort=%b required 0000",
               {ram_we, busy, rd_rsp_valid, lock_abort});
    end
    n_cmp++;
    if ({ram_write_addr, ram_data} !== 56'h0) begin
      n_err++;
      $display("FAIL reset_wport: got addr=%h data=%h required 0/0", ram_write_addr, ram_data);
    end
    rst_n = 1'b1;
    req_valid = 4'b1111;
    req_last  = 4'b1111;
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL reset_rr_ptr: got ready=%b required 0001", req_ready);
    end
    clear_inputs();
    #1;
    n_cmp++;
    if (req_ready !== 4'b0000) begin
      n_err++;
      $display("FAIL idle_no_valid: got ready=%b required 0000", req_ready);
    end
  endtask

  task automatic test_single_beats();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0100, 40'h11);
    set_req(2, 1'b1, 1'b1, 16'h0200, 40'h22);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0001) begin
      n_err++;
      $display("FAIL single_grant0: got ready=%b required 0001", req_ready);
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 40'h0);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL single_grant2: got ready=%b required 0100", req_ready);
    end
    n_cmp++;
    if ({ram_we, ram_write_addr, ram_data} !== {1'b1, 16'h0100, 40'h11}) begin
      n_err++;
      $display("FAIL single_wr0: got we=%b addr=%h data=%h required 1/0100/11",
               ram_we, ram_write_addr, ram_data);
    end
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 16'h0, 40'h0);
    #1;
    n_cmp++;
    if ({ram_we, ram_write_addr, ram_data} !== {1'b1, 16'h0200, 40'h22}) begin
      n_err++;
      $display("FAIL single_wr2: got we=%b addr=%h data=%h required 1/0200/22",
               ram_we, ram_write_addr, ram_data);
    end
    @(negedge clk);
    n_cmp++;
    if (ram_we !== 1'b0) begin
      n_err++;
      $display("FAIL single_we_drop: got we=%b required 0", ram_we);
    end
  endtask

  task automatic test_burst_lock();
    do_reset();
    set_req(3, 1'b1, 1'b1, 16'h03F0, 40'h33);
    set_req(1, 1'b1, 1'b0, 16'h0010, 40'hA0);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0010) begin
      n_err++;
      $display("FAIL burst_first: got ready=%b required 0010", req_ready);
    end
    for (int b = 1; b <= 2; b++) begin
      @(negedge clk);
      set_req(1, 1'b1, (b == 2), 16'h0010 + 16'(b), 40'hA0 + 40'(b));
      #1;
      n_cmp++;
      if ({req_ready, busy, ram_we, ram_write_addr} !== {4'b0010, 1'b1, 1'b1, 16'h0010 + 16'(b - 1)}) begin
        n_err++;
        $display("FAIL burst_beat%0d: got ready=%b busy=%b we=%b addr=%h required 0010/1/1/%h",
                 b, req_ready, busy, ram_we, ram_write_addr, 16'h0010 + 16'(b - 1));
      end
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 16'h0, 40'h0);
    #1;
    n_cmp++;
    if ({req_ready, busy, ram_write_addr, ram_data} !== {4'b1000, 1'b0, 16'h0012, 40'hA2}) begin
      n_err++;
      $display("FAIL burst_release: got ready=%b busy=%b addr=%h data=%h required 1000/0/0012/a2",
               req_ready, busy, ram_write_addr, ram_data);
    end
    @(negedge clk);
    set_req(3, 1'b0, 1'b0, 16'h0, 40'h0);
    #1;
    n_cmp++;
    if ({ram_we, ram_write_addr, ram_data} !== {1'b1, 16'h03F0, 40'h33}) begin
      n_err++;
      $display("FAIL burst_next_wr: got we=%b addr=%h data=%h required 1/03f0/33",
               ram_we, ram_write_addr, ram_data);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ready;
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, 16'h0300 + 16'(i), 40'h5000 + 40'(i));
    for (int k = 0; k < 6; k++) begin
      #1;
      exp_ready = 4'b0001 << (k % 4);
      n_cmp++;
      if (req_ready !== exp_ready) begin
        n_err++;
        $display("FAIL rr_grant%0d: got ready=%b required %b", k, req_ready, exp_ready);
      end
      if (k > 0) begin
        n_cmp++;
        if ({ram_we, ram_write_addr} !== {1'b1, 16'h0300 + 16'((k - 1) % 4)}) begin
          n_err++;
          $display("FAIL rr_write%0d: got we=%b addr=%h required 1/%h",
                   k, ram_we, ram_write_addr, 16'h0300 + 16'((k - 1) % 4));
        end
      end
      @(negedge clk);
    end
    clear_inputs();
  endtask

  task automatic test_read_coherency();
    do_reset();
    set_req(0, 1'b1, 1'b1, 16'h0040, 40'h00000000AB);
    rd_req  = 1'b1;
    rd_addr = 16'h0040;
    #1;
    n_cmp++;
    if (ram_read_addr !== 16'h0040) begin
      n_err++;
      $display("FAIL rd_addr_pass: got %h required 0040", ram_read_addr);
    end
    @(negedge clk);
    set_req(0, 1'b0, 1'b0, 16'h0, 40'h0);
    #1;
    n_cmp++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 40'h0}) begin
      n_err++;
      $display("FAIL rd_same_cycle: got valid=%b data=%h required 1/0", rd_rsp_valid, rd_rsp_data);
    end
    @(negedge clk);
    rd_req = 1'b0;
    #1;
    n_cmp++;
    if ({rd_rsp_valid, rd_rsp_data} !== {1'b1, 40'hAB}) begin
      n_err++;
      $display("FAIL rd_after_write: got valid=%b data=%h required 1/ab", rd_rsp_valid, rd_rsp_data);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_rsp_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_valid_drop: got %b required 0", rd_rsp_valid);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    set_req(0, 1'b1, 1'b0, 16'h0500, 40'h55);
    @(negedge clk);
    set_req(0, 1'b1, 1'b0, 16'h0501, 40'h56);
    rd_req  = 1'b1;
    rd_addr = 16'h0500;
    @(posedge clk);
    #1;
    n_cmp++;
    if ({ram_we, busy, rd_rsp_valid} !== 3'b111) begin
      n_err++;
      $display("FAIL mid_pre_reset: got we/busy/rsp=%b required 111", {ram_we, busy, rd_rsp_valid});
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ram_we, busy, rd_rsp_valid} !== 3'b000) begin
      n_err++;
      $display("FAIL mid_async_reset: got we/busy/rsp=%b required 000", {ram_we, busy, rd_rsp_valid});
    end
    clear_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1'b1, 1'b1, 16'h0600, 40'h66);
    set_req(2, 1'b1, 1'b1, 16'h0620, 40'h62);
    #1;
    n_cmp++;
    if ({req_ready, busy} !== {4'b0001, 1'b0}) begin
      n_err++;
      $display("FAIL mid_restart: got ready=%b busy=%b required 0001/0", req_ready, busy);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({ram_we, ram_write_addr} !== {1'b1, 16'h0600}) begin
      n_err++;
      $display("FAIL mid_restart_wr: got we=%b addr=%h required 1/0600", ram_we, ram_write_addr);
    end
  endtask

  task automatic test_lock_timeout();
    do_reset();
    set_req(2, 1'b1, 1'b0, 16'h0700, 40'h77);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL to_lock_grant: got ready=%b required 0100", req_ready);
    end
    @(negedge clk);
    set_req(2, 1'b0, 1'b0, 16'h0, 40'h0);
    set_req(1, 1'b1, 1'b1, 16'h0710, 40'h71);
    set_req(3, 1'b1, 1'b1, 16'h0730, 40'h73);
`ifdef PAGE_ARB_LOCK_TIMEOUT_EN
    for (int k = 1; k <= 9; k++) begin
      #1;
      n_cmp++;
      if ({busy, lock_abort, req_ready} !== {1'b1, 1'b0, 4'b0100}) begin
        n_err++;
        $display("FAIL to_hold%0d: got busy=%b abort=%b ready=%b required 1/0/0100",
                 k, busy, lock_abort, req_ready);
      end
      @(negedge clk);
    end
    #1;
    n_cmp++;
    if ({busy, lock_abort, req_ready} !== {1'b0, 1'b1, 4'b1000}) begin
      n_err++;
      $display("FAIL to_abort: got busy=%b abort=%b ready=%b required 0/1/1000",
               busy, lock_abort, req_ready);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({lock_abort, ram_we, ram_write_addr} !== {1'b0, 1'b1, 16'h0730}) begin
      n_err++;
      $display("FAIL to_after: got abort=%b we=%b addr=%h required 0/1/0730",
               lock_abort, ram_we, ram_write_addr);
    end
`else
    for (int k = 1; k <= 110; k++) begin
      #1;
      n_cmp++;
      if ({busy, lock_abort, req_ready} !== {1'b1, 1'b0, 4'b0100}) begin
        n_err++;
        $display("FAIL hold%0d: got busy=%b abort=%b ready=%b required 1/0/0100",
                 k, busy, lock_abort, req_ready);
      end
      @(negedge clk);
    end
    set_req(2, 1'b1, 1'b1, 16'h0701, 40'h78);
    #1;
    n_cmp++;
    if (req_ready !== 4'b0100) begin
      n_err++;
      $display("FAIL hold_owner_last: got ready=%b required 0100", req_ready);
    end
    @(negedge clk);
    clear_inputs();
    #1;
    n_cmp++;
    if ({busy, ram_we, ram_write_addr} !== {1'b0, 1'b1, 16'h0701}) begin
      n_err++;
      $display("FAIL hold_release: got busy=%b we=%b addr=%h required 0/1/0701",
               busy, ram_we, ram_write_addr);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    clear_inputs();
    test_reset();
    test_single_beats();
    test_burst_lock();
    test_round_robin();
    test_read_coherency();
    test_reset_mid_burst();
    test_lock_timeout();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
